// File: rtl/cpu_types_pkg.sv
// Shared MIPS decode types: opcodes, decode FSM states and the ID/EX latch layout.
// Pure declarations; no logic, no latency, no flow control.
package cpu_types_pkg;

    localparam int WORD_W  = 32;
    localparam int RADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [RADDR_W-1:0] LINK_REG = 5'd31;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } decode_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]  pc;
        logic [WORD_W-1:0]  rdat1;
        logic [WORD_W-1:0]  rdat2;
        logic [WORD_W-1:0]  imm;
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] wsel;
    } id_ex_t;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/decode_stage_imm_ext.sv
// Immediate extension by opcode: zero-extend logical ops, shift LUI, sign-extend the rest.
// Combinational, zero latency; no flow control.
module imm_ext
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm,
    output logic [WORD_W-1:0] imm_ext
);

    logic [WORD_W-1:0] zext_w;
    logic [WORD_W-1:0] sext_w;
    logic [WORD_W-1:0] lui_w;

    assign zext_w = {{(WORD_W-16){1'b0}}, imm};
    assign sext_w = {{(WORD_W-16){imm[15]}}, imm};
    assign lui_w  = WORD_W'({imm, 16'h0000});

    always_comb begin
        imm_ext = sext_w;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = zext_w;
            OP_LUI:                   imm_ext = lui_w;
            default:                  imm_ext = sext_w;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: operand fetch with WB bypass, load-use stall, ID/EX latch.
// Latency 1 cycle; holds the latch while out_ready=0 and drops in_ready on stall/hold.
module decode_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = cpu_types_pkg::WORD_W,
    parameter int RADDR_W   = cpu_types_pkg::RADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_instr,
    input  logic [WORD_W-1:0]  in_pc,
    output logic               in_ready,
    output logic [RADDR_W-1:0] rsel1,
    output logic [RADDR_W-1:0] rsel2,
    input  logic [WORD_W-1:0]  rdat1,
    input  logic [WORD_W-1:0]  rdat2,
    input  logic               wb_wen,
    input  logic [RADDR_W-1:0] wb_wsel,
    input  logic [WORD_W-1:0]  wb_wdat,
    input  logic               ex_memread,
    input  logic [RADDR_W-1:0] ex_wsel,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_pc,
    output logic [WORD_W-1:0]  out_rdat1,
    output logic [WORD_W-1:0]  out_rdat2,
    output logic [WORD_W-1:0]  out_imm,
    output logic [5:0]         out_opcode,
    output logic [5:0]         out_funct,
    output logic [RADDR_W-1:0] out_rs,
    output logic [RADDR_W-1:0] out_rt,
    output logic [RADDR_W-1:0] out_wsel
);

    decode_state_t state_q, state_d;
    logic          out_valid_q, out_valid_d;
    id_ex_t        id_ex_q, id_ex_d;

    logic [5:0]         opcode;
    logic [RADDR_W-1:0] rs, rt, rd;
    logic [WORD_W-1:0]  imm_w;
    logic [WORD_W-1:0]  op1, op2;
    logic [RADDR_W-1:0] dst;
    logic               hazard;
    logic               advance;
    id_ex_t             decoded;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];

    assign rsel1 = rs;
    assign rsel2 = rt;

    imm_ext #(.WORD_W(WORD_W)) u_imm_ext (
        .opcode  (opcode),
        .imm     (in_instr[15:0]),
        .imm_ext (imm_w)
    );

    // r0 reads as zero regardless of bypass; a WB to r0 is never forwarded.
    always_comb begin
        op1 = rdat1;
        op2 = rdat2;
        if (rs == '0) begin
            op1 = '0;
        end else if (BYPASS_EN && wb_wen && (wb_wsel != '0) && (wb_wsel == rs)) begin
            op1 = wb_wdat;
        end
        if (rt == '0) begin
            op2 = '0;
        end else if (BYPASS_EN && wb_wen && (wb_wsel != '0) && (wb_wsel == rt)) begin
            op2 = wb_wdat;
        end
    end

    always_comb begin
        dst = rt;
        case (opcode)
            OP_RTYPE: dst = rd;
            OP_JAL:   dst = LINK_REG;
            default:  dst = rt;
        endcase
    end

    assign hazard = in_valid && ex_memread && (ex_wsel != '0) &&
                    ((ex_wsel == rs) || (uses_rt(opcode) && (ex_wsel == rt)));

    assign advance = out_ready || !out_valid_q;

    always_comb begin
        decoded        = '0;
        decoded.pc     = in_pc;
        decoded.rdat1  = op1;
        decoded.rdat2  = op2;
        decoded.imm    = imm_w;
        decoded.opcode = opcode;
        decoded.funct  = in_instr[5:0];
        decoded.rs     = rs;
        decoded.rt     = rt;
        decoded.wsel   = dst;
    end

    // Flush outranks stall and hold; STALL lasts exactly one advancing cycle.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        id_ex_d     = id_ex_q;
        in_ready    = 1'b0;
        if (flush) begin
            state_d     = RUN;
            out_valid_d = 1'b0;
            in_ready    = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (advance) begin
                        if (hazard) begin
                            out_valid_d = 1'b0;
                            state_d     = STALL;
                        end else begin
                            id_ex_d     = decoded;
                            out_valid_d = in_valid;
                            in_ready    = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (advance) begin
                        id_ex_d     = decoded;
                        out_valid_d = in_valid;
                        state_d     = RUN;
                        in_ready    = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            id_ex_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            id_ex_q     <= id_ex_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = id_ex_q.pc;
    assign out_rdat1  = id_ex_q.rdat1;
    assign out_rdat2  = id_ex_q.rdat2;
    assign out_imm    = id_ex_q.imm;
    assign out_opcode = id_ex_q.opcode;
    assign out_funct  = id_ex_q.funct;
    assign out_rs     = id_ex_q.rs;
    assign out_rt     = id_ex_q.rt;
    assign out_wsel   = id_ex_q.wsel;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: bypass, immediates, load-use stall, hold and flush.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic [4:0]  rsel1, rsel2;
    logic [31:0] rdat1, rdat2;
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        ex_memread;
    logic [4:0]  ex_wsel;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc, out_rdat1, out_rdat2, out_imm;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_wsel;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    decode_stage dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .rsel1      (rsel1),
        .rsel2      (rsel2),
        .rdat1      (rdat1),
        .rdat2      (rdat2),
        .wb_wen     (wb_wen),
        .wb_wsel    (wb_wsel),
        .wb_wdat    (wb_wdat),
        .ex_memread (ex_memread),
        .ex_wsel    (ex_wsel),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_rdat1  (out_rdat1),
        .out_rdat2  (out_rdat2),
        .out_imm    (out_imm),
        .out_opcode (out_opcode),
        .out_funct  (out_funct),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_wsel   (out_wsel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", n_chk, 0);
        $fatal(1, "bench timed out");
    end

    initial begin
        nRST = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        rdat1 = '0; rdat2 = '0; wb_wen = 1'b0; wb_wsel = '0; wb_wdat = '0;
        ex_memread = 1'b0; ex_wsel = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset and idle
        tick(); tick();
        chk("rst_valid",  out_valid,  0);
        chk("rst_pc",     out_pc,     0);
        chk("rst_rdat1",  out_rdat1,  0);
        chk("rst_imm",    out_imm,    0);
        chk("rst_wsel",   out_wsel,   0);
        chk("rst_opcode", out_opcode, 0);
        nRST = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // ORI r3,r1,0xFFFF
        in_valid = 1'b1; in_pc = 32'h100; in_instr = enc_i(6'h0D, 5'd1, 5'd3, 16'hFFFF);
        rdat1 = 32'd5; rdat2 = 32'd9; out_ready = 1'b1;
        #1;
        chk("ori_rsel1", rsel1, 1);
        chk("ori_rsel2", rsel2, 3);
        chk("ori_in_ready", in_ready, 1);
        tick();
        chk("ori_valid",  out_valid,  1);
        chk("ori_rdat1",  out_rdat1,  5);
        chk("ori_imm",    out_imm,    32'h0000FFFF);
        chk("ori_wsel",   out_wsel,   3);
        chk("ori_pc",     out_pc,     32'h100);
        chk("ori_opcode", out_opcode, 32'h0D);

        // ADDI r4,r2,-1 with WB bypass of r2, then with a write to r0
        in_pc = 32'h104; in_instr = enc_i(6'h08, 5'd2, 5'd4, 16'hFFFF);
        rdat1 = 32'd0; wb_wen = 1'b1; wb_wsel = 5'd2; wb_wdat = 32'h10;
        tick();
        chk("addi_byp_rdat1", out_rdat1, 32'h10);
        chk("addi_imm",       out_imm,   32'hFFFFFFFF);
        chk("addi_wsel",      out_wsel,  4);
        wb_wsel = 5'd0; rdat1 = 32'h22;
        tick();
        chk("addi_nobyp_rdat1", out_rdat1, 32'h22);
        wb_wen = 1'b0;

        // Load-use on rs: LW r7 in EX, ADD r8,r7,r1 in ID
        ex_memread = 1'b1; ex_wsel = 5'd7;
        in_pc = 32'h108; in_instr = enc_r(5'd7, 5'd1, 5'd8, 6'h20);
        rdat1 = 32'h77; rdat2 = 32'h11;
        #1;
        chk("lu_in_ready_n", in_ready, 0);
        tick();
        chk("lu_bubble", out_valid, 0);
        #1;
        chk("lu_stall_in_ready", in_ready, 1);
        tick();
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_rs",    out_rs,    7);
        chk("lu_add_wsel",  out_wsel,  8);
        chk("lu_add_funct", out_funct, 32'h20);
        chk("lu_add_rdat1", out_rdat1, 32'h77);

        // Load-use on rt of a store: SW r7,4(r3)
        in_pc = 32'h10C; in_instr = enc_i(6'h2B, 5'd3, 5'd7, 16'h0004);
        #1;
        chk("sw_in_ready_n", in_ready, 0);
        tick();
        chk("sw_bubble", out_valid, 0);
        tick();
        chk("sw_valid", out_valid, 1);
        chk("sw_rt",    out_rt,    7);
        chk("sw_imm",   out_imm,   4);

        // ADDI with rt=7 does not read rt, so no stall
        in_pc = 32'h110; in_instr = enc_i(6'h08, 5'd3, 5'd7, 16'h0001);
        #1;
        chk("addi_rt_nostall", in_ready, 1);
        tick();
        chk("addi_rt_valid", out_valid, 1);
        chk("addi_rt_pc",    out_pc,    32'h110);
        ex_memread = 1'b0; ex_wsel = '0;

        // Backpressure hold for 3 cycles, then flush
        in_pc = 32'h200; in_instr = enc_i(6'h0D, 5'd1, 5'd5, 16'h00AA); rdat1 = 32'h55;
        tick();
        chk("hold_load_pc", out_pc, 32'h200);
        out_ready = 1'b0;
        in_pc = 32'h300; in_instr = enc_i(6'h0D, 5'd2, 5'd6, 16'h00BB); rdat1 = 32'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_in_ready", in_ready, 0);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_pc",    out_pc,    32'h200);
            chk("hold_rdat1", out_rdat1, 32'h55);
            chk("hold_imm",   out_imm,   32'hAA);
        end
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1);
        tick();
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        out_ready = 1'b1;

        // JAL: link register destination, r0 source reads zero
        in_pc = 32'h400; in_instr = {6'h03, 26'h0000010}; rdat1 = 32'hDEAD;
        #1;
        chk("jal_in_ready", in_ready, 1);
        tick();
        chk("jal_valid", out_valid, 1);
        chk("jal_wsel",  out_wsel,  31);
        chk("jal_rdat1", out_rdat1, 0);
        chk("jal_imm",   out_imm,   32'h10);

        // LUI and ANDI immediates
        in_instr = enc_i(6'h0F, 5'd0, 5'd9, 16'h8001);
        tick();
        chk("lui_imm", out_imm, 32'h80010000);
        in_instr = enc_i(6'h0C, 5'd0, 5'd9, 16'h8001);
        tick();
        chk("andi_imm", out_imm, 32'h00008001);

        // Reset while stalled
        ex_memread = 1'b1; ex_wsel = 5'd4;
        in_instr = enc_r(5'd4, 5'd1, 5'd2, 6'h20);
        tick();
        chk("midstall_bubble", out_valid, 0);
        nRST = 1'b0;
        tick();
        chk("midstall_rst_valid", out_valid, 0);
        nRST = 1'b1; in_valid = 1'b0; ex_memread = 1'b0;
        #1;
        chk("midstall_in_ready", in_ready, 1);
        tick();
        chk("midstall_idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
